// File: rtl/dag_if.sv
// Sequencer/bus-facing signal bundle of the data address generator (dag_unit).
interface dag_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ps_dg_en;
  logic              ps_dg_pre;
  logic              ps_dg_mod_only;
  logic [2:0]        ps_dg_isel;
  logic [2:0]        ps_dg_msel;
  logic              ps_dg_wrt_en;
  logic [4:0]        ps_dg_wrt_add;
  logic              ps_dg_rd_en;
  logic [4:0]        ps_dg_rd_add;
  logic [DATA_W-1:0] bc_dt;
  logic [ADDR_W-1:0] dg_dm_add;
  logic [DATA_W-1:0] dg_bc_dt;

  modport master (
    output ps_dg_en, ps_dg_pre, ps_dg_mod_only, ps_dg_isel, ps_dg_msel,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_en, ps_dg_rd_add, bc_dt,
    input  dg_dm_add, dg_bc_dt
  );

  modport slave (
    input  ps_dg_en, ps_dg_pre, ps_dg_mod_only, ps_dg_isel, ps_dg_msel,
           ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_en, ps_dg_rd_add, bc_dt,
    output dg_dm_add, dg_bc_dt
  );
endinterface

// File: rtl/dag_unit.sv
// Data address generator: I/M/L/B register file with pre/post-modify addressing.
// Define DG_CIRC_EN to build the L/B registers and circular-buffer wrap.
module dag_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic   clk,
  input logic   reset,
  dag_if.slave  bus
);
  localparam int CW = ADDR_W + 2;

  localparam logic [1:0] GRP_I = 2'b00;
  localparam logic [1:0] GRP_M = 2'b01;
  localparam logic [1:0] GRP_L = 2'b10;
  localparam logic [1:0] GRP_B = 2'b11;

  logic [ADDR_W-1:0] i_reg [8];
  logic [DATA_W-1:0] m_reg [8];
`ifdef DG_CIRC_EN
  logic [ADDR_W-1:0] l_reg [8];
  logic [ADDR_W-1:0] b_reg [8];
`endif

  logic [ADDR_W-1:0] dm_add_q;
  logic [DATA_W-1:0] bc_dt_q;

  logic [ADDR_W-1:0] i_cur;
  logic [ADDR_W-1:0] nxt;
  logic [DATA_W-1:0] rd_data;

  logic [1:0] wr_grp;
  logic [2:0] wr_idx;
  logic [1:0] rd_grp;
  logic [2:0] rd_idx;

  assign wr_grp = bus.ps_dg_wrt_add[4:3];
  assign wr_idx = bus.ps_dg_wrt_add[2:0];
  assign rd_grp = bus.ps_dg_rd_add[4:3];
  assign rd_idx = bus.ps_dg_rd_add[2:0];
  assign i_cur  = i_reg[bus.ps_dg_isel];

  // The sum is formed in ADDR_W+2 signed bits so that a negative M or an
  // overshoot past B+L is visible to the wrap compares before truncation.
  logic signed [CW-1:0] t_sum;
  logic signed [CW-1:0] m_ext;
`ifdef DG_CIRC_EN
  logic signed [CW-1:0] l_ext;
  logic signed [CW-1:0] b_ext;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    m_ext = CW'($signed(m_reg[bus.ps_dg_msel]));
    t_sum = CW'(i_cur) + m_ext;
    nxt   = t_sum[ADDR_W-1:0];
`ifdef DG_CIRC_EN
    l_ext = CW'(l_reg[bus.ps_dg_isel]);
    b_ext = CW'(b_reg[bus.ps_dg_isel]);
    if (l_ext != '0) begin
      if (t_sum >= b_ext + l_ext)
        nxt = ADDR_W'(t_sum - l_ext);
      else if (t_sum < b_ext)
        nxt = ADDR_W'(t_sum + l_ext);
    end
`endif
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_grp)
      GRP_I: rd_data = DATA_W'(i_reg[rd_idx]);
      GRP_M: rd_data = m_reg[rd_idx];
`ifdef DG_CIRC_EN
      GRP_L: rd_data = DATA_W'(l_reg[rd_idx]);
      GRP_B: rd_data = DATA_W'(b_reg[rd_idx]);
`else
      GRP_L, GRP_B: rd_data = '0;
`endif
      default: rd_data = '0;
    endcase
  end

  // NOTE: the register file is flop-based and fully reset because software
  // relies on every ureg reading 0 after reset; a RAM macro could not do that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
`ifdef DG_CIRC_EN
        l_reg[k] <= '0;
        b_reg[k] <= '0;
`endif
      end
      dm_add_q <= '0;
      bc_dt_q  <= '0;
    end else begin
      if (bus.ps_dg_en && !bus.ps_dg_mod_only)
        dm_add_q <= bus.ps_dg_pre ? nxt : i_cur;

      if (bus.ps_dg_en && (bus.ps_dg_mod_only || !bus.ps_dg_pre))
        i_reg[bus.ps_dg_isel] <= nxt;

      // Placed after the I update: a ureg write to the same I takes priority.
      if (bus.ps_dg_wrt_en) begin
        unique case (wr_grp)
          GRP_I: i_reg[wr_idx] <= ADDR_W'(bus.bc_dt);
          GRP_M: m_reg[wr_idx] <= bus.bc_dt;
`ifdef DG_CIRC_EN
          GRP_L: l_reg[wr_idx] <= ADDR_W'(bus.bc_dt);
          GRP_B: b_reg[wr_idx] <= ADDR_W'(bus.bc_dt);
`else
          GRP_L, GRP_B: ;
`endif
          default: ;
        endcase
      end

      if (bus.ps_dg_rd_en)
        bc_dt_q <= rd_data;
    end
  end

  assign bus.dg_dm_add = dm_add_q;
  assign bus.dg_bc_dt  = bc_dt_q;
endmodule

// File: tb/tb_dag_unit.sv
// Directed self-checking bench for dag_unit (linear paths; circular paths when DG_CIRC_EN is defined).
module tb_dag_unit;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [1:0] G_I = 2'b00;
  localparam logic [1:0] G_M = 2'b01;
  localparam logic [1:0] G_L = 2'b10;
  localparam logic [1:0] G_B = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dag_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dag_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus changes just after a falling edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ps_dg_en       = 1'b0;
    bus.ps_dg_pre      = 1'b0;
    bus.ps_dg_mod_only = 1'b0;
    bus.ps_dg_isel     = 3'd0;
    bus.ps_dg_msel     = 3'd0;
    bus.ps_dg_wrt_en   = 1'b0;
    bus.ps_dg_wrt_add  = 5'd0;
    bus.ps_dg_rd_en    = 1'b0;
    bus.ps_dg_rd_add   = 5'd0;
    bus.bc_dt          = '0;
  endtask

  task automatic ureg_write(input logic [1:0] grp, input logic [2:0] idx,
                            input logic [DATA_W-1:0] val);
    bus.ps_dg_wrt_en  = 1'b1;
    bus.ps_dg_wrt_add = {grp, idx};
    bus.bc_dt         = val;
    cycle();
    clear_inputs();
  endtask

  task automatic ureg_read(input logic [1:0] grp, input logic [2:0] idx,
                           output logic [DATA_W-1:0] val);
    bus.ps_dg_rd_en  = 1'b1;
    bus.ps_dg_rd_add = {grp, idx};
    cycle();
    val = bus.dg_bc_dt;
    clear_inputs();
  endtask

  task automatic set_access(input logic pre, input logic mod_only, input logic [2:0] sel);
    bus.ps_dg_en       = 1'b1;
    bus.ps_dg_pre      = pre;
    bus.ps_dg_mod_only = mod_only;
    bus.ps_dg_isel     = sel;
    bus.ps_dg_msel     = sel;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] rd;
    reset = 1'b0;
    clear_inputs();
    cycle();
    checks++;
    if (bus.dg_dm_add !== 16'h0000) begin
      errors++; $display("FAIL reset_dm_add: got %h expected 0000", bus.dg_dm_add);
    end
    checks++;
    if (bus.dg_bc_dt !== 16'h0000) begin
      errors++; $display("FAIL reset_bc_dt: got %h expected 0000", bus.dg_bc_dt);
    end
    reset = 1'b1;
    cycle();
    ureg_write(G_I, 3'd0, 16'h0010);
    set_access(1'b0, 1'b0, 3'd0);
    cycle();
    checks++;
    if (bus.dg_dm_add !== 16'h0010) begin
      errors++; $display("FAIL reset_pre_addr: got %h expected 0010", bus.dg_dm_add);
    end
    // Reset lands while an access and a write to I0 are both pending.
    bus.ps_dg_wrt_en  = 1'b1;
    bus.ps_dg_wrt_add = {G_I, 3'd0};
    bus.bc_dt         = 16'h5555;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.dg_dm_add !== 16'h0000) begin
      errors++; $display("FAIL reset_async_dm_add: got %h expected 0000", bus.dg_dm_add);
    end
    cycle();
    clear_inputs();
    reset = 1'b1;
    cycle();
    ureg_read(G_I, 3'd0, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++; $display("FAIL reset_i0_readback: got %h expected 0000", rd);
    end
  endtask

  task automatic test_post_linear();
    logic [ADDR_W-1:0] exp_addr [3];
    logic [DATA_W-1:0] rd;
    exp_addr[0] = 16'h0100;
    exp_addr[1] = 16'h0104;
    exp_addr[2] = 16'h0108;
    ureg_write(G_I, 3'd1, 16'h0100);
    ureg_write(G_M, 3'd1, 16'h0004);
    set_access(1'b0, 1'b0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (bus.dg_dm_add !== exp_addr[k]) begin
        errors++; $display("FAIL post_linear_addr%0d: got %h expected %h", k, bus.dg_dm_add, exp_addr[k]);
      end
    end
    clear_inputs();
    ureg_read(G_I, 3'd1, rd);
    checks++;
    if (rd !== 16'h010C) begin
      errors++; $display("FAIL post_linear_i1: got %h expected 010c", rd);
    end
  endtask

  task automatic test_pre_negative();
    logic [DATA_W-1:0] rd;
    ureg_write(G_I, 3'd2, 16'h0000);
    ureg_write(G_M, 3'd2, 16'hFFFF);
    set_access(1'b1, 1'b0, 3'd2);
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_dm_add !== 16'hFFFF) begin
      errors++; $display("FAIL pre_neg_addr: got %h expected ffff", bus.dg_dm_add);
    end
    cycle();
    checks++;
    if (bus.dg_dm_add !== 16'hFFFF) begin
      errors++; $display("FAIL pre_neg_hold: got %h expected ffff", bus.dg_dm_add);
    end
    ureg_read(G_I, 3'd2, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++; $display("FAIL pre_neg_i2: got %h expected 0000", rd);
    end
  endtask

`ifdef DG_CIRC_EN
  task automatic test_circular();
    logic [ADDR_W-1:0] exp_a [4];
    logic [ADDR_W-1:0] exp_b [2];
    exp_a[0] = 16'h0203; exp_a[1] = 16'h0204; exp_a[2] = 16'h0200; exp_a[3] = 16'h0201;
    exp_b[0] = 16'h0201; exp_b[1] = 16'h0204;
    ureg_write(G_B, 3'd3, 16'h0200);
    ureg_write(G_L, 3'd3, 16'h0005);
    ureg_write(G_I, 3'd3, 16'h0203);
    ureg_write(G_M, 3'd3, 16'h0001);
    set_access(1'b0, 1'b0, 3'd3);
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (bus.dg_dm_add !== exp_a[k]) begin
        errors++; $display("FAIL circ_up_addr%0d: got %h expected %h", k, bus.dg_dm_add, exp_a[k]);
      end
    end
    clear_inputs();
    ureg_write(G_I, 3'd3, 16'h0201);
    ureg_write(G_M, 3'd3, 16'hFFFE);
    set_access(1'b0, 1'b0, 3'd3);
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (bus.dg_dm_add !== exp_b[k]) begin
        errors++; $display("FAIL circ_down_addr%0d: got %h expected %h", k, bus.dg_dm_add, exp_b[k]);
      end
    end
    clear_inputs();
  endtask
`else
  task automatic test_no_circ();
    logic [DATA_W-1:0] rd;
    ureg_write(G_B, 3'd3, 16'h0200);
    ureg_write(G_L, 3'd3, 16'h0005);
    ureg_read(G_L, 3'd3, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++; $display("FAIL nocirc_l3_read: got %h expected 0000", rd);
    end
    ureg_read(G_B, 3'd3, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++; $display("FAIL nocirc_b3_read: got %h expected 0000", rd);
    end
    // With L ignored, the sequence that would wrap stays linear.
    ureg_write(G_I, 3'd3, 16'h0204);
    ureg_write(G_M, 3'd3, 16'h0001);
    set_access(1'b0, 1'b1, 3'd3);
    cycle();
    clear_inputs();
    ureg_read(G_I, 3'd3, rd);
    checks++;
    if (rd !== 16'h0205) begin
      errors++; $display("FAIL nocirc_linear_i3: got %h expected 0205", rd);
    end
  endtask
`endif

  task automatic test_collision();
    logic [DATA_W-1:0] rd;
    ureg_write(G_I, 3'd4, 16'h0010);
    ureg_write(G_M, 3'd4, 16'h0002);
    set_access(1'b0, 1'b0, 3'd4);
    bus.ps_dg_wrt_en  = 1'b1;
    bus.ps_dg_wrt_add = {G_I, 3'd4};
    bus.bc_dt         = 16'h0ABC;
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_dm_add !== 16'h0010) begin
      errors++; $display("FAIL collision_addr: got %h expected 0010", bus.dg_dm_add);
    end
    ureg_read(G_I, 3'd4, rd);
    checks++;
    if (rd !== 16'h0ABC) begin
      errors++; $display("FAIL collision_i4: got %h expected 0abc", rd);
    end
  endtask

  task automatic test_mod_only();
    ureg_write(G_I, 3'd5, 16'h0020);
    ureg_write(G_M, 3'd5, 16'h0008);
    set_access(1'b0, 1'b1, 3'd5);
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_dm_add !== 16'h0010) begin
      errors++; $display("FAIL modonly_addr_hold: got %h expected 0010", bus.dg_dm_add);
    end
    bus.ps_dg_rd_en  = 1'b1;
    bus.ps_dg_rd_add = {G_I, 3'd5};
    #1;
    checks++;
    if (bus.dg_bc_dt !== 16'h0ABC) begin
      errors++; $display("FAIL modonly_bc_before_edge: got %h expected 0abc", bus.dg_bc_dt);
    end
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_bc_dt !== 16'h0028) begin
      errors++; $display("FAIL modonly_i5_read: got %h expected 0028", bus.dg_bc_dt);
    end
    cycle();
    checks++;
    if (bus.dg_bc_dt !== 16'h0028) begin
      errors++; $display("FAIL modonly_bc_hold: got %h expected 0028", bus.dg_bc_dt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] rd;
    // Read and write of I6 in one cycle returns the old value.
    ureg_write(G_I, 3'd6, 16'h0030);
    bus.ps_dg_rd_en   = 1'b1;
    bus.ps_dg_rd_add  = {G_I, 3'd6};
    bus.ps_dg_wrt_en  = 1'b1;
    bus.ps_dg_wrt_add = {G_I, 3'd6};
    bus.bc_dt         = 16'h0040;
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_bc_dt !== 16'h0030) begin
      errors++; $display("FAIL rdwr_same_old: got %h expected 0030", bus.dg_bc_dt);
    end
    ureg_read(G_I, 3'd6, rd);
    checks++;
    if (rd !== 16'h0040) begin
      errors++; $display("FAIL rdwr_same_new: got %h expected 0040", rd);
    end
    // Write then access on the very next cycle uses the written value,
    // while a simultaneous write to a different register also completes.
    ureg_write(G_M, 3'd7, 16'h0003);
    ureg_write(G_I, 3'd7, 16'h0077);
    set_access(1'b1, 1'b0, 3'd7);
    bus.ps_dg_wrt_en  = 1'b1;
    bus.ps_dg_wrt_add = {G_M, 3'd0};
    bus.bc_dt         = 16'h1234;
    cycle();
    clear_inputs();
    checks++;
    if (bus.dg_dm_add !== 16'h007A) begin
      errors++; $display("FAIL wr_then_access: got %h expected 007a", bus.dg_dm_add);
    end
    ureg_read(G_M, 3'd0, rd);
    checks++;
    if (rd !== 16'h1234) begin
      errors++; $display("FAIL parallel_write_m0: got %h expected 1234", rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_post_linear();
    test_pre_negative();
`ifdef DG_CIRC_EN
    test_circular();
`else
    test_no_circ();
`endif
    test_collision();
    test_mod_only();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
